// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline control types and helpers
package pipe_pkg;

  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic wmem;
  } ctrl_t;

  localparam int REG_ZERO = 0;

  // Stage index width; a single-stage chain still needs a 1-bit index port.
  function automatic int stage_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stage.sv
// rtl/pipe_ctrl_stage.sv - one pipeline register stage with clear, flush, stall and control gating
module pipe_ctrl_stage
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          stall,
  input  logic          flush,
  input  logic          d_valid,
  input  ctrl_t         d_ctrl,
  input  logic [DW-1:0] d_alu,
  input  logic [DW-1:0] d_b,
  input  logic [RW-1:0] d_rn,
  output logic          q_valid,
  output ctrl_t         q_ctrl,
  output logic [DW-1:0] q_alu,
  output logic [DW-1:0] q_b,
  output logic [RW-1:0] q_rn
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_alu   <= '0;
      q_b     <= '0;
      q_rn    <= '0;
    end else if (flush) begin
      // Data fields are left in place; only validity and controls are killed.
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (!stall) begin
      q_valid <= d_valid;
      q_ctrl  <= d_valid ? d_ctrl : '0;
      q_alu   <= d_alu;
      q_b     <= d_b;
      q_rn    <= d_rn;
    end
  end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// rtl/pipe_ctrl_chain.sv - configurable-depth EX/MEM pipeline register with pending-write query
module pipe_ctrl_chain
  import pipe_pkg::*;
#(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int DEPTH = 1,
  parameter int SW    = stage_idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          stall,
  input  logic          flush,
  input  logic          i_valid,
  input  logic          i_wreg,
  input  logic          i_m2reg,
  input  logic          i_wmem,
  input  logic [DW-1:0] i_alu,
  input  logic [DW-1:0] i_b,
  input  logic [RW-1:0] i_rn,
  output logic          o_valid,
  output logic          o_wreg,
  output logic          o_m2reg,
  output logic          o_wmem,
  output logic [DW-1:0] o_alu,
  output logic [DW-1:0] o_b,
  output logic [RW-1:0] o_rn,
  input  logic [RW-1:0] q_rn,
  output logic          q_hit,
  output logic [SW-1:0] q_stage,
  output logic          q_load,
  output logic [DW-1:0] q_alu
);

  ctrl_t         in_ctrl;
  logic          d_valid [DEPTH];
  ctrl_t         d_ctrl  [DEPTH];
  logic [DW-1:0] d_alu   [DEPTH];
  logic [DW-1:0] d_b     [DEPTH];
  logic [RW-1:0] d_rn    [DEPTH];
  logic          s_valid [DEPTH];
  ctrl_t         s_ctrl  [DEPTH];
  logic [DW-1:0] s_alu   [DEPTH];
  logic [DW-1:0] s_b     [DEPTH];
  logic [RW-1:0] s_rn    [DEPTH];

  assign in_ctrl = '{wreg: i_wreg, m2reg: i_m2reg, wmem: i_wmem};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_in
      assign d_valid[k] = i_valid;
      assign d_ctrl[k]  = in_ctrl;
      assign d_alu[k]   = i_alu;
      assign d_b[k]     = i_b;
      assign d_rn[k]    = i_rn;
    end else begin : g_link
      assign d_valid[k] = s_valid[k-1];
      assign d_ctrl[k]  = s_ctrl[k-1];
      assign d_alu[k]   = s_alu[k-1];
      assign d_b[k]     = s_b[k-1];
      assign d_rn[k]    = s_rn[k-1];
    end

    pipe_ctrl_stage #(
      .DW(DW),
      .RW(RW)
    ) u_stage (
      .clk    (clk),
      .clr    (clr),
      .stall  (stall),
      .flush  (flush),
      .d_valid(d_valid[k]),
      .d_ctrl (d_ctrl[k]),
      .d_alu  (d_alu[k]),
      .d_b    (d_b[k]),
      .d_rn   (d_rn[k]),
      .q_valid(s_valid[k]),
      .q_ctrl (s_ctrl[k]),
      .q_alu  (s_alu[k]),
      .q_b    (s_b[k]),
      .q_rn   (s_rn[k])
    );
  end

  assign o_valid = s_valid[DEPTH-1];
  assign o_wreg  = s_ctrl[DEPTH-1].wreg;
  assign o_m2reg = s_ctrl[DEPTH-1].m2reg;
  assign o_wmem  = s_ctrl[DEPTH-1].wmem;
  assign o_alu   = s_alu[DEPTH-1];
  assign o_b     = s_b[DEPTH-1];
  assign o_rn    = s_rn[DEPTH-1];

  // Scan oldest to youngest so the lowest matching index is the last written.
  always_comb begin
    q_hit   = 1'b0;
    q_stage = '0;
    q_load  = 1'b0;
    q_alu   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (s_valid[k] && s_ctrl[k].wreg && (s_rn[k] == q_rn) && (q_rn != RW'(REG_ZERO))) begin
        q_hit   = 1'b1;
        q_stage = SW'(k);
        q_load  = s_ctrl[k].m2reg;
        q_alu   = s_alu[k];
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// tb/tb_pipe_ctrl_chain.sv - scoreboard bench for DEPTH=3 and DEPTH=1 chains
module tb_pipe_ctrl_chain;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
  } ent_t;

  logic        clk = 1'b0;
  logic        clr, stall, flush;
  logic        i_valid, i_wreg, i_m2reg, i_wmem;
  logic [31:0] i_alu, i_b;
  logic [4:0]  i_rn, q_rn;

  logic        o3_valid, o3_wreg, o3_m2reg, o3_wmem, q3_hit, q3_load;
  logic [31:0] o3_alu, o3_b, q3_alu;
  logic [4:0]  o3_rn;
  logic [1:0]  q3_stage;
  logic        o1_valid, o1_wreg, o1_m2reg, o1_wmem, q1_hit, q1_load;
  logic [31:0] o1_alu, o1_b, q1_alu;
  logic [4:0]  o1_rn;
  logic [0:0]  q1_stage;

  int   n_chk  = 0;
  int   n_fail = 0;
  ent_t q3[$];
  ent_t q1[$];
  ent_t e3, e1;
  ent_t vec [8];

  always #5 clk = ~clk;

  pipe_ctrl_chain #(.DW(32), .RW(5), .DEPTH(3)) u3 (
    .clk(clk), .clr(clr), .stall(stall), .flush(flush),
    .i_valid(i_valid), .i_wreg(i_wreg), .i_m2reg(i_m2reg), .i_wmem(i_wmem),
    .i_alu(i_alu), .i_b(i_b), .i_rn(i_rn),
    .o_valid(o3_valid), .o_wreg(o3_wreg), .o_m2reg(o3_m2reg), .o_wmem(o3_wmem),
    .o_alu(o3_alu), .o_b(o3_b), .o_rn(o3_rn),
    .q_rn(q_rn), .q_hit(q3_hit), .q_stage(q3_stage), .q_load(q3_load), .q_alu(q3_alu)
  );

  pipe_ctrl_chain #(.DW(32), .RW(5), .DEPTH(1)) u1 (
    .clk(clk), .clr(clr), .stall(stall), .flush(flush),
    .i_valid(i_valid), .i_wreg(i_wreg), .i_m2reg(i_m2reg), .i_wmem(i_wmem),
    .i_alu(i_alu), .i_b(i_b), .i_rn(i_rn),
    .o_valid(o1_valid), .o_wreg(o1_wreg), .o_m2reg(o1_m2reg), .o_wmem(o1_wmem),
    .o_alu(o1_alu), .o_b(o1_b), .o_rn(o1_rn),
    .q_rn(q_rn), .q_hit(q1_hit), .q_stage(q1_stage), .q_load(q1_load), .q_alu(q1_alu)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle; the expected exit entry is queued only if the edge captures it.
  task automatic cyc(input logic c, input logic s, input logic f, input logic v,
                     input logic w, input logic m, input logic wm,
                     input logic [31:0] a, input logic [31:0] bb, input logic [4:0] r);
    clr = c; stall = s; flush = f; i_valid = v;
    i_wreg = w; i_m2reg = m; i_wmem = wm; i_alu = a; i_b = bb; i_rn = r;
    if (c || f) begin
      q3.delete();
      q1.delete();
    end else if (!s && v) begin
      q3.push_back('{w, m, wm, a, bb, r});
      q1.push_back('{w, m, wm, a, bb, r});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bub();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  // An entry leaves the chain on an edge with no clr, flush or stall.
  always @(negedge clk) begin
    if (!clr && !stall && !flush && o3_valid) begin
      if (q3.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb3_unexpected actual=%0h expected=none", o3_alu);
      end else begin
        e3 = q3.pop_front();
        chk("sb3_entry", {o3_wreg, o3_m2reg, o3_wmem, o3_alu, o3_b, o3_rn}, e3);
      end
    end
    if (!clr && !stall && !flush && o1_valid) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb1_unexpected actual=%0h expected=none", o1_alu);
      end else begin
        e1 = q1.pop_front();
        chk("sb1_entry", {o1_wreg, o1_m2reg, o1_wmem, o1_alu, o1_b, o1_rn}, e1);
      end
    end
    if (!o3_valid) chk("gate3", {o3_wreg, o3_m2reg, o3_wmem}, 3'b000);
    if (!o1_valid) chk("gate1", {o1_wreg, o1_m2reg, o1_wmem}, 3'b000);
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec = '{
      '{1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'hdead_beef, 5'd1},
      '{1'b1, 1'b1, 1'b0, 32'hffff_ffff, 32'h0000_0000, 5'd31},
      '{1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h1234_5678, 5'd0},
      '{1'b1, 1'b0, 1'b1, 32'ha5a5_a5a5, 32'h5a5a_5a5a, 5'd16},
      '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'hffff_ffff, 5'd15},
      '{1'b1, 1'b1, 1'b1, 32'h7fff_ffff, 32'h8000_0001, 5'd30},
      '{1'b1, 1'b0, 1'b0, 32'hcafe_f00d, 32'h0000_0000, 5'd2},
      '{1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0002, 5'd3}
    };
    q_rn = 5'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    // Reset mid-stream with every input nonzero
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 5'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h101, 32'h201, 5'd5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h102, 32'h202, 5'd6);
    q_rn = 5'd5;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hffff_ffff, 32'hffff_ffff, 5'd5);
    chk("rst3_o", {o3_valid, o3_wreg, o3_m2reg, o3_wmem, o3_alu, o3_b, o3_rn}, 0);
    chk("rst3_q", {q3_hit, q3_stage, q3_load, q3_alu}, 0);
    chk("rst1_o", {o1_valid, o1_wreg, o1_m2reg, o1_wmem, o1_alu, o1_b, o1_rn}, 0);
    chk("rst1_q", {q1_hit, q1_stage, q1_load, q1_alu}, 0);

    // Latency through three stages
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h55, 5'd5);
    chk("lat_e1_valid", o3_valid, 1'b0);
    chk("lat_e1_q", {q3_hit, q3_stage, q3_load, q3_alu}, {1'b1, 2'd0, 1'b0, 32'h1234});
    chk("lat1_out", {o1_valid, o1_rn, o1_alu}, {1'b1, 5'd5, 32'h1234});
    bub();
    chk("lat_e2_valid", o3_valid, 1'b0);
    chk("lat_e2_stage", {q3_hit, q3_stage}, {1'b1, 2'd1});
    bub();
    chk("lat_e3_out", {o3_valid, o3_rn, o3_alu}, {1'b1, 5'd5, 32'h1234});
    chk("lat_e3_stage", {q3_hit, q3_stage}, {1'b1, 2'd2});

    // Bubble carrying write controls must not assert them nor hit
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h99, 32'h98, 5'd9);
    q_rn = 5'd9;
    #1;
    chk("bub_q3", q3_hit, 1'b0);
    chk("bub_q1", q1_hit, 1'b0);
    bub();
    bub();
    chk("bub_exit", {o3_valid, o3_wreg, o3_wmem, o3_rn}, {1'b0, 1'b0, 1'b0, 5'd9});
    chk("bub_exit_q", q3_hit, 1'b0);

    // Stall two cycles, then stall+flush together
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11, 32'hb1, 5'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h22, 32'hb2, 5'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h33, 32'hb3, 5'd3);
    chk("sf_pre", {o3_valid, o3_wreg, o3_m2reg, o3_wmem, o3_alu, o3_b, o3_rn},
        {4'b1100, 32'h11, 32'hb1, 5'd1});
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44, 32'h44, 5'd4);
      chk("stall3_hold", {o3_valid, o3_wreg, o3_m2reg, o3_wmem, o3_alu, o3_b, o3_rn},
          {4'b1100, 32'h11, 32'hb1, 5'd1});
      chk("stall1_hold", {o1_valid, o1_wreg, o1_m2reg, o1_wmem, o1_alu, o1_b, o1_rn},
          {4'b1001, 32'h33, 32'hb3, 5'd3});
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h55, 32'h55, 5'd30);
    chk("flush3_ctl", {o3_valid, o3_wreg, o3_m2reg, o3_wmem}, 4'b0000);
    chk("flush3_data", {o3_alu, o3_b, o3_rn}, {32'h11, 32'hb1, 5'd1});
    chk("flush1_out", {o1_valid, o1_alu, o1_rn}, {1'b0, 32'h33, 5'd3});
    q_rn = 5'd2;
    #1;
    chk("flush_q_mid", q3_hit, 1'b0);
    q_rn = 5'd30;
    #1;
    chk("flush_q_entering", {q3_hit, q1_hit}, 2'b00);

    // Youngest-first priority and register-zero exclusion
    q_rn = 5'd7;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA, 32'h0, 5'd7);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 5'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hB, 32'h0, 5'd7);
    chk("young3", {q3_hit, q3_stage, q3_load, q3_alu}, {1'b1, 2'd0, 1'b1, 32'hB});
    chk("young1", {q1_hit, q1_stage, q1_load, q1_alu}, {1'b1, 1'b0, 1'b1, 32'hB});
    q_rn = 5'd0;
    #1;
    chk("reg0_q3", {q3_hit, q3_stage, q3_load, q3_alu}, 0);
    q_rn = 5'd7;
    bub();
    chk("young3_shift", {q3_hit, q3_stage, q3_load, q3_alu}, {1'b1, 2'd1, 1'b1, 32'hB});

    // Drop-in stream on the single-stage chain
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, vec[i].wreg, vec[i].m2reg, vec[i].wmem,
          vec[i].alu, vec[i].b, vec[i].rn);
      chk("dropin1", {o1_valid, o1_wreg, o1_m2reg, o1_wmem, o1_alu, o1_b, o1_rn},
          {1'b1, vec[i]});
    end
    for (int i = 0; i < 4; i++) bub();
    chk("drain_q3", q3.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
